mantissa_align_pipe: RTL and testbench

Pipelined, parametrised mantissa alignment stage for the floating-point add/sub datapath. It extends each incoming mantissa with its hidden bit and guard/round/sticky positions, then right-shifts the operand with the smaller exponent. The shifted-out bits fold into a true sticky bit, and large shifts saturate. It sits between exponent compare and the mantissa adder, with a valid/ready handshake on both sides and a two-stage register pipeline.

---
 rtl/mantissa_align_pipe.sv | 112 +++++++++++
 tb/tb_mantissa_align_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_align_pipe.sv
// Two-stage mantissa alignment for FP add/sub: builds {hidden, fraction, G, R, S} operands and right-shifts the smaller one.
// Optional macro MANT_ALIGN_STICKY_EN folds shifted-out bits into a sticky LSB; undefined gives a plain truncating shift.
module mantissa_align_pipe #(
    parameter int MANTISSA_WIDTH = 23,
    parameter int SHIFT_WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MANTISSA_WIDTH-1:0] ma,
    input  logic [MANTISSA_WIDTH-1:0] mb,
    input  logic                      a_hidden,
    input  logic                      b_hidden,
    input  logic [SHIFT_WIDTH-1:0]    shift_spaces,
    input  logic [1:0]                exp_magnitude,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MANTISSA_WIDTH+3:0] mantissa_a,
    output logic [MANTISSA_WIDTH+3:0] mantissa_b,
    output logic                      shift_sat
);

    localparam int W   = MANTISSA_WIDTH + 4;
    localparam int CW  = $clog2(W + 1);
    // Shift register wide enough for both the raw amount and the clamp value W.
    localparam int SHW = (SHIFT_WIDTH > CW) ? SHIFT_WIDTH : CW;
    localparam logic [SHW-1:0] W_SH = SHW'(W);

    function automatic logic [SHW-1:0] clamp_shift(input logic [SHIFT_WIDTH-1:0] amt);
        logic [SHW-1:0] ext;
        ext = SHW'(amt);
        return (ext >= W_SH) ? W_SH : ext;
    endfunction

    // A clamp of W empties the operand, so saturation needs no special case here.
    function automatic logic [W-1:0] align_shift(input logic [W-1:0] op, input logic [SHW-1:0] amt);
        logic [W-1:0] shifted;
`ifdef MANT_ALIGN_STICKY_EN
        logic [W-1:0] lost_mask;
        logic         lost;
        shifted   = op >> amt;
        lost_mask = ~({W{1'b1}} << amt);
        lost      = |(op & lost_mask);
        return {shifted[W-1:1], shifted[0] | lost};
`else
        shifted = op >> amt;
        return shifted;
`endif
    endfunction

    logic           vld_p1, vld_p2;
    logic [W-1:0]   op_a_p1, op_b_p1;
    logic [SHW-1:0] shamt_p1;
    logic           shift_a_p1, shift_b_p1, sat_p1;
    logic           adv1, adv2, accept;
    logic           shift_a_in, shift_b_in;
    logic [SHW-1:0] clamp_in;

    assign adv2      = !vld_p2 || out_ready;
    assign adv1      = !vld_p1 || adv2;
    assign in_ready  = adv1;
    assign accept    = in_valid && adv1;
    assign out_valid = vld_p2;

    assign shift_a_in = (exp_magnitude == 2'b00);
    assign shift_b_in = (exp_magnitude == 2'b10);
    assign clamp_in   = clamp_shift(shift_spaces);

    // Stage 1: operand build, selector decode and shift clamp
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            op_a_p1    <= '0;
            op_b_p1    <= '0;
            shamt_p1   <= '0;
            shift_a_p1 <= 1'b0;
            shift_b_p1 <= 1'b0;
            sat_p1     <= 1'b0;
        end else begin
            if (adv1) begin
                vld_p1 <= accept;
            end
            if (accept) begin
                op_a_p1    <= {a_hidden, ma, 3'b000};
                op_b_p1    <= {b_hidden, mb, 3'b000};
                shamt_p1   <= clamp_in;
                shift_a_p1 <= shift_a_in;
                shift_b_p1 <= shift_b_in;
                sat_p1     <= (shift_a_in || shift_b_in) && (clamp_in == W_SH);
            end
        end
    end

    // Stage 2: shift the selected operand and register the aligned result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2     <= 1'b0;
            mantissa_a <= '0;
            mantissa_b <= '0;
            shift_sat  <= 1'b0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                mantissa_a <= shift_a_p1 ? align_shift(op_a_p1, shamt_p1) : op_a_p1;
                mantissa_b <= shift_b_p1 ? align_shift(op_b_p1, shamt_p1) : op_b_p1;
                shift_sat  <= sat_p1;
            end
        end
    end

endmodule

// File: tb/tb_mantissa_align_pipe.sv
// Scoreboard bench for mantissa_align_pipe: directed vector table, backpressure, reset mid-flight and random traffic.
module tb_mantissa_align_pipe;

    localparam int MW = 23;
    localparam int SW = 8;
    localparam int W  = 27;
`ifdef MANT_ALIGN_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    typedef struct {
        logic [MW-1:0] ma;
        logic [MW-1:0] mb;
        logic          ah;
        logic          bh;
        logic [SW-1:0] sh;
        logic [1:0]    mag;
        logic [W-1:0]  ea;
        logic [W-1:0]  eb;
        logic          esat;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [MW-1:0] ma, mb;
    logic          a_hidden, b_hidden;
    logic [SW-1:0] shift_spaces;
    logic [1:0]    exp_magnitude;
    logic          out_valid, out_ready;
    logic [W-1:0]  mantissa_a, mantissa_b;
    logic          shift_sat;

    always #5 clk = ~clk;

    mantissa_align_pipe #(.MANTISSA_WIDTH(MW), .SHIFT_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ma(ma), .mb(mb), .a_hidden(a_hidden), .b_hidden(b_hidden),
        .shift_spaces(shift_spaces), .exp_magnitude(exp_magnitude),
        .out_valid(out_valid), .out_ready(out_ready),
        .mantissa_a(mantissa_a), .mantissa_b(mantissa_b), .shift_sat(shift_sat)
    );

    int   total = 0;
    int   passed = 0;
    int   out_count = 0;
    bit   rand_rdy = 1'b0;
    exp_t sb[$];
    vec_t vecs[9];
    vec_t bpv[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Bit-serial reference: shift one place at a time, collecting dropped bits.
    function automatic exp_t model(input vec_t v);
        exp_t         e;
        logic [W-1:0] oa, ob, t;
        logic         lost;
        oa = {v.ah, v.ma, 3'b000};
        ob = {v.bh, v.mb, 3'b000};
        e.a = oa;
        e.b = ob;
        e.sat = 1'b0;
        if (v.mag == 2'b10 || v.mag == 2'b00) begin
            t = (v.mag == 2'b10) ? ob : oa;
            lost = 1'b0;
            if (int'(v.sh) >= W) begin
                e.sat = 1'b1;
                lost = (t != '0);
                t = '0;
            end else begin
                for (int i = 0; i < int'(v.sh); i++) begin
                    lost = lost | t[0];
                    t = t >> 1;
                end
            end
            if (STK) t[0] = t[0] | lost;
            if (v.mag == 2'b10) e.b = t;
            else e.a = t;
        end
        return e;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.ma  = MW'($urandom);
        v.mb  = MW'($urandom);
        v.ah  = 1'($urandom_range(0, 1));
        v.bh  = 1'($urandom_range(0, 1));
        v.sh  = SW'($urandom_range(0, 40));
        v.mag = 2'($urandom_range(0, 3));
        v.ea  = '0;
        v.eb  = '0;
        v.esat = 1'b0;
        return v;
    endfunction

    task automatic send(input vec_t v, input exp_t e);
        int n = 0;
        ma = v.ma;
        mb = v.mb;
        a_hidden = v.ah;
        b_hidden = v.bh;
        shift_spaces = v.sh;
        exp_magnitude = v.mag;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", n);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ma = MW'($urandom);
        mb = MW'($urandom);
        shift_spaces = SW'($urandom);
        exp_magnitude = 2'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_output: a=%0h b=%0h with empty scoreboard, required none", mantissa_a, mantissa_b);
            end else begin
                e = sb.pop_front();
                chk("out_mantissa_a", mantissa_a, e.a);
                chk("out_mantissa_b", mantissa_b, e.b);
                chk("out_shift_sat", shift_sat, e.sat);
                out_count++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        exp_t e0;
        int   start_cnt;

        vecs[0] = '{23'h0, 23'h0, 1'b1, 1'b1, 8'd1, 2'b10, 27'h4000000, 27'h2000000, 1'b0};
        vecs[1] = '{23'h0, 23'h000001, 1'b1, 1'b1, 8'd5, 2'b10, 27'h4000000,
                    (STK ? 27'h0200001 : 27'h0200000), 1'b0};
        vecs[2] = '{23'h7FFFFF, 23'h123456, 1'b1, 1'b1, 8'd31, 2'b00,
                    (STK ? 27'h0000001 : 27'h0000000), 27'h491A2B0, 1'b1};
        vecs[3] = '{23'h000010, 23'h0ABCDE, 1'b0, 1'b1, 8'd9, 2'b11, 27'h0000080, 27'h455E6F0, 1'b0};
        vecs[4] = '{23'h7FFFFF, 23'h0, 1'b1, 1'b0, 8'd40, 2'b01, 27'h7FFFFF8, 27'h0, 1'b0};
        vecs[5] = '{23'h0, 23'h7FFFFF, 1'b0, 1'b1, 8'd26, 2'b10, 27'h0, 27'h0000001, 1'b0};
        vecs[6] = '{23'h2AAAAA, 23'h0, 1'b1, 1'b0, 8'd27, 2'b10, 27'h5555550, 27'h0, 1'b1};
        vecs[7] = '{23'h000001, 23'h400000, 1'b1, 1'b0, 8'd0, 2'b10, 27'h4000008, 27'h2000000, 1'b0};
        vecs[8] = '{23'h0, 23'h7FFFFF, 1'b0, 1'b1, 8'd255, 2'b00, 27'h0, 27'h7FFFFF8, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ma = '0;
        mb = '0;
        a_hidden = 1'b0;
        b_hidden = 1'b0;
        shift_spaces = '0;
        exp_magnitude = 2'b00;

        #12;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_mantissa_a", mantissa_a, 0);
        chk("reset_mantissa_b", mantissa_b, 0);
        chk("reset_shift_sat", shift_sat, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);

        // Latency: accepted at edge k, visible after edge k+1.
        out_ready = 1'b1;
        send(vecs[0], '{vecs[0].ea, vecs[0].eb, vecs[0].esat});
        chk("latency_edge_k", out_valid, 0);
        @(posedge clk);
        #1;
        chk("latency_edge_k1", out_valid, 1);

        for (int i = 1; i < 9; i++) begin
            send(vecs[i], '{vecs[i].ea, vecs[i].eb, vecs[i].esat});
        end
        drain();

        // Backpressure: two acceptances fill the pipe, then outputs must hold.
        for (int i = 0; i < 5; i++) begin
            bpv[i] = rand_vec();
            bpv[i].mag = (i % 2 == 0) ? 2'b10 : 2'b00;
        end
        e0 = model(bpv[0]);
        start_cnt = out_count;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(bpv[i], model(bpv[i]));
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #2;
                chk("bp_out_valid", out_valid, 1);
                for (int c = 0; c < 3; c++) begin
                    if (c > 0) begin
                        @(posedge clk);
                        #2;
                    end
                    chk("bp_in_ready_low", in_ready, 0);
                    chk("bp_hold_a", mantissa_a, e0.a);
                    chk("bp_hold_b", mantissa_b, e0.b);
                    chk("bp_hold_sat", shift_sat, e0.sat);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_result_count", out_count - start_cnt, 5);

        // Reset with both stages full discards everything in flight.
        out_ready = 1'b0;
        send(vecs[2], '{vecs[2].ea, vecs[2].eb, vecs[2].esat});
        send(vecs[3], '{vecs[3].ea, vecs[3].eb, vecs[3].esat});
        chk("full_in_ready_low", in_ready, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_mantissa_a", mantissa_a, 0);
        chk("midrst_mantissa_b", mantissa_b, 0);
        chk("midrst_shift_sat", shift_sat, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        start_cnt = out_count;
        send(vecs[1], '{vecs[1].ea, vecs[1].eb, vecs[1].esat});
        chk("post_reset_latency_k", out_valid, 0);
        @(posedge clk);
        #1;
        chk("post_reset_latency_k1", out_valid, 1);
        drain();
        chk("post_reset_count", out_count - start_cnt, 1);

        // Random traffic with random gaps and random downstream stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v = rand_vec();
            send(v, model(v));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        #2;
        out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
